periph_amo_adapter: RTL

- Sits directly downstream of the peripheral request FIFO, between the cluster-side peripheral port and peripherals that lack native atomic support.
- Plain reads and writes pass through with zero added latency.
- Requests carrying a valid atop are executed as a locked read-modify-write sequence. The old value is returned to the requester; the write-phase response is suppressed.

---
 rtl/periph_amo_pkg.sv | 43 ++++
 rtl/periph_amo_alu.sv | 42 ++++
 rtl/periph_amo_adapter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/periph_amo_pkg.sv
// Shared definitions for the peripheral AMO adapter.
//   - funct5 encodings of the RISC-V AMO opcodes (atop[4:0])
//   - amo_op_e : typed view of those encodings
//   - fsm_state_e : sequencer states of the adapter
// LR/SC encodings are only honoured when PERIPH_AMO_LRSC_EN is defined.
package periph_amo_pkg;

   localparam logic [4:0] F5_ADD  = 5'b00000;
   localparam logic [4:0] F5_SWAP = 5'b00001;
   localparam logic [4:0] F5_LR   = 5'b00010;
   localparam logic [4:0] F5_SC   = 5'b00011;
   localparam logic [4:0] F5_XOR  = 5'b00100;
   localparam logic [4:0] F5_OR   = 5'b01000;
   localparam logic [4:0] F5_AND  = 5'b01100;
   localparam logic [4:0] F5_MIN  = 5'b10000;
   localparam logic [4:0] F5_MAX  = 5'b10100;
   localparam logic [4:0] F5_MINU = 5'b11000;
   localparam logic [4:0] F5_MAXU = 5'b11100;

   typedef enum logic [4:0] {
      AmoAdd  = F5_ADD,
      AmoSwap = F5_SWAP,
      AmoLr   = F5_LR,
      AmoSc   = F5_SC,
      AmoXor  = F5_XOR,
      AmoOr   = F5_OR,
      AmoAnd  = F5_AND,
      AmoMin  = F5_MIN,
      AmoMax  = F5_MAX,
      AmoMinu = F5_MINU,
      AmoMaxu = F5_MAXU
   } amo_op_e;

   typedef enum logic [2:0] {
      StIdle,
      StRd,
      StRdWait,
      StWr,
      StWrWait,
      StResp
   } fsm_state_e;

endpackage

// File: rtl/periph_amo_alu.sv
// Combinational AMO datapath: computes the value written back by a read-modify-write.
// Ports:
//   i_op     : funct5 of the atomic
//   i_a      : old value read from the peripheral
//   i_b      : operand supplied by the requester
//   o_result : value to write back (32-bit wrapping)
//   o_unsup  : funct5 not supported by this build
// With PERIPH_AMO_LRSC_EN defined, LR passes i_a and SC passes i_b; otherwise both are unsupported.
module periph_amo_alu
   import periph_amo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic [4:0]            i_op,
   input  logic [DATA_WIDTH-1:0] i_a,
   input  logic [DATA_WIDTH-1:0] i_b,
   output logic [DATA_WIDTH-1:0] o_result,
   output logic                  o_unsup
);

   always_comb begin
      o_result = '0;
      o_unsup  = 1'b0;
      case (i_op)
         AmoAdd:  o_result = i_a + i_b;
         AmoSwap: o_result = i_b;
         AmoXor:  o_result = i_a ^ i_b;
         AmoOr:   o_result = i_a | i_b;
         AmoAnd:  o_result = i_a & i_b;
         AmoMin:  o_result = ($signed(i_a) < $signed(i_b)) ? i_a : i_b;
         AmoMax:  o_result = ($signed(i_a) > $signed(i_b)) ? i_a : i_b;
         AmoMinu: o_result = (i_a < i_b) ? i_a : i_b;
         AmoMaxu: o_result = (i_a > i_b) ? i_a : i_b;
`ifdef PERIPH_AMO_LRSC_EN
         AmoLr:   o_result = i_a;
         AmoSc:   o_result = i_b;
`endif
         default: o_unsup = 1'b1;
      endcase
   end

endmodule

// File: rtl/periph_amo_adapter.sv
// Adds atomic-memory-operation support in front of peripherals that lack it.
// Plain reads/writes are forwarded combinationally (zero added latency) with an outstanding-
// transaction limit; requests with atop_i[5]=1 run as a locked read-then-write sequence that
// returns the old value and swallows the write response.
// Ports:
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   req_i..be_i, gnt_o           : upstream request channel (atop_i = {valid, funct5})
//   r_valid_o, r_opc_o, r_rdata_o: upstream response channel
//   req_o..be_o, gnt_i           : downstream request channel
//   r_valid_i, r_opc_i, r_rdata_i: downstream response channel
// Optional feature macro: PERIPH_AMO_LRSC_EN (LR/SC with a single address reservation).
module periph_amo_adapter
   import periph_amo_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_i,
   input  logic [ADDR_WIDTH-1:0] add_i,
   input  logic                  wen_i,
   input  logic [5:0]            atop_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [BE_WIDTH-1:0]   be_i,
   output logic                  gnt_o,
   output logic                  r_valid_o,
   output logic                  r_opc_o,
   output logic [DATA_WIDTH-1:0] r_rdata_o,
   output logic                  req_o,
   output logic [ADDR_WIDTH-1:0] add_o,
   output logic                  wen_o,
   output logic [DATA_WIDTH-1:0] wdata_o,
   output logic [BE_WIDTH-1:0]   be_o,
   input  logic                  gnt_i,
   input  logic                  r_valid_i,
   input  logic                  r_opc_i,
   input  logic [DATA_WIDTH-1:0] r_rdata_i
);

   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   if (DATA_WIDTH != 32) begin : g_bad_data_width
      $error("periph_amo_adapter: DATA_WIDTH must be 32");
   end
   if (MAX_OUTSTANDING < 1) begin : g_bad_max_outstanding
      $error("periph_amo_adapter: MAX_OUTSTANDING must be >= 1");
   end

   fsm_state_e            r_state, w_state_nxt;
   logic [CNT_W-1:0]      r_cnt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [BE_WIDTH-1:0]   r_be;
   logic [DATA_WIDTH-1:0] r_operand, r_old;
   logic [4:0]            r_op;
   logic                  r_err;

   logic                  w_room, w_accept, w_cnt_inc, w_cnt_dec;
   logic [4:0]            w_alu_op;
   logic [DATA_WIDTH-1:0] w_alu_res;
   logic                  w_alu_unsup;
   logic                  w_is_sc, w_res_hit, w_rd_only;

   assign w_room = (r_cnt < CNT_MAX);

   // In IDLE the ALU decodes the incoming funct5 so support is known at accept time;
   // afterwards it works on the latched opcode.
   assign w_alu_op = (r_state == StIdle) ? atop_i[4:0] : r_op;

   periph_amo_alu #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_alu (
      .i_op     (w_alu_op),
      .i_a      (r_old),
      .i_b      (r_operand),
      .o_result (w_alu_res),
      .o_unsup  (w_alu_unsup)
   );

`ifdef PERIPH_AMO_LRSC_EN
   logic                  r_res_valid;
   logic [ADDR_WIDTH-1:0] r_res_addr;

   assign w_is_sc   = (atop_i[4:0] == F5_SC);
   assign w_res_hit = r_res_valid && (r_res_addr == add_i);
   assign w_rd_only = (r_op == F5_LR);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_res_valid <= 1'b0;
         r_res_addr  <= '0;
      end else if (r_state == StRdWait && r_valid_i && !r_opc_i && w_rd_only) begin
         r_res_valid <= 1'b1;
         r_res_addr  <= r_addr;
      end else if ((w_accept && (w_is_sc || w_res_hit)) || (w_cnt_inc && !wen_i && w_res_hit)) begin
         // SC always consumes the reservation; any write or AMO to the address kills it.
         r_res_valid <= 1'b0;
      end
   end
`else
   assign w_is_sc   = 1'b0;
   assign w_res_hit = 1'b0;
   assign w_rd_only = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= StIdle;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_cnt_inc   = 1'b0;
      w_cnt_dec   = 1'b0;
      gnt_o       = 1'b0;
      r_valid_o   = 1'b0;
      r_opc_o     = 1'b0;
      r_rdata_o   = '0;
      req_o       = 1'b0;
      add_o       = add_i;
      wen_o       = wen_i;
      wdata_o     = wdata_i;
      be_o        = be_i;
      unique case (r_state)
         StIdle: begin
            r_valid_o = r_valid_i;
            r_opc_o   = r_opc_i;
            r_rdata_o = r_rdata_i;
            w_cnt_dec = r_valid_i && (r_cnt != '0);
            if (req_i && atop_i[5]) begin
               // Atomics only start once every pass-through response has drained.
               gnt_o    = (r_cnt == '0);
               w_accept = gnt_o;
               if (w_accept) begin
                  if (w_alu_unsup)  w_state_nxt = StResp;
                  else if (w_is_sc) w_state_nxt = w_res_hit ? StWr : StResp;
                  else              w_state_nxt = StRd;
               end
            end else begin
               req_o     = req_i && w_room;
               gnt_o     = gnt_i && w_room;
               w_cnt_inc = req_o && gnt_i;
            end
         end
         StRd: begin
            req_o   = 1'b1;
            wen_o   = 1'b1;
            add_o   = r_addr;
            be_o    = r_be;
            wdata_o = '0;
            if (gnt_i) w_state_nxt = StRdWait;
         end
         StRdWait: begin
            if (r_valid_i) w_state_nxt = (r_opc_i || w_rd_only) ? StResp : StWr;
         end
         StWr: begin
            req_o   = 1'b1;
            wen_o   = 1'b0;
            add_o   = r_addr;
            be_o    = r_be;
            wdata_o = w_alu_res;
            if (gnt_i) w_state_nxt = StWrWait;
         end
         StWrWait: begin
            if (r_valid_i) w_state_nxt = StResp;
         end
         StResp: begin
            r_valid_o   = 1'b1;
            r_opc_o     = r_err;
            r_rdata_o   = r_old;
            w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
      if (rst_i) begin
         gnt_o     = 1'b0;
         r_valid_o = 1'b0;
         r_opc_o   = 1'b0;
         r_rdata_o = '0;
         req_o     = 1'b0;
         add_o     = '0;
         wen_o     = 1'b0;
         wdata_o   = '0;
         be_o      = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt     <= '0;
         r_addr    <= '0;
         r_be      <= '0;
         r_operand <= '0;
         r_op      <= '0;
         r_old     <= '0;
         r_err     <= 1'b0;
      end else begin
         unique case ({w_cnt_inc, w_cnt_dec})
            2'b10:   r_cnt <= r_cnt + CNT_W'(1);
            2'b01:   r_cnt <= r_cnt - CNT_W'(1);
            default: r_cnt <= r_cnt;
         endcase
         if (w_accept) begin
            r_addr    <= add_i;
            r_be      <= be_i;
            r_operand <= wdata_i;
            r_op      <= atop_i[4:0];
            // Failed SC reports 1; successful SC and unsupported ops report 0.
            r_old     <= (w_is_sc && !w_res_hit) ? DATA_WIDTH'(1) : '0;
            r_err     <= w_alu_unsup;
         end
         if (r_state == StRdWait && r_valid_i) begin
            r_old <= r_rdata_i;
            r_err <= r_opc_i;
         end
         if (r_state == StWrWait && r_valid_i) begin
            r_err <= r_err | r_opc_i;
         end
      end
   end

endmodule
